// File: rtl/gauss_pkg.sv
// Shared widths, constants and the normalisation helper for the
// Gaussian result receiver and its output FIFO.
package gauss_pkg;

    // Width of the unnormalised 1-2-1 / 2-4-2 / 1-2-1 weighted sum
    localparam int SUM_W      = 15;
    // Width of a normalised output pixel
    localparam int PIX_W      = 8;
    // The kernel weights add up to 16, so normalising is a shift by 4
    localparam int NORM_SHIFT = 4;
    // Half of the divisor, added before the shift for round-half-up
    localparam int ROUND      = 8;
    // Largest value an output pixel can carry
    localparam int PIX_MAX    = 255;

    // One FIFO word: frame/line tags travel with the pixel
    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [PIX_W-1:0] pix;
    } fifo_word_t;

    localparam int FIFO_W = $bits(fifo_word_t);

    // Round-half-up divide by 16, clamped to the pixel range.
    // The sum is widened by one bit so the rounding add cannot overflow.
    function automatic logic [PIX_W-1:0] normalize(input logic [SUM_W-1:0] sum);
        logic [SUM_W:0]            w_rounded;
        logic [SUM_W-NORM_SHIFT:0] w_scaled;
        w_rounded = {1'b0, sum} + (SUM_W+1)'(ROUND);
        w_scaled  = (SUM_W-NORM_SHIFT+1)'(w_rounded >> NORM_SHIFT);
        if (w_scaled > (SUM_W-NORM_SHIFT+1)'(PIX_MAX)) begin
            return PIX_W'(PIX_MAX);
        end
        return w_scaled[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/gauss_fifo.sv
// Synchronous first-word-fall-through FIFO for tagged output pixels.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module gauss_fifo
    import gauss_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  fifo_word_t i_wdata,
    input  logic       i_pop,
    output fifo_word_t o_rdata,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_word_t      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_push;
    logic            w_pop;

    // Writes into a full FIFO and reads from an empty one are ignored
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

    // Head of the queue is visible without a read cycle
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage array: captures the pushed word at the write pointer
    // NOTE: the data array is deliberately left out of reset; an empty FIFO
    // never exposes it, and keeping reset off the array lets it map to RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep the count
    // NOTE: every state register here uses <= so all flops update from the
    // same pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gauss_result_rx.sv
// Receives unnormalised 3x3 Gaussian sums in raster order, normalises them
// to 8-bit pixels, drops the border samples whose window was not yet full,
// tags frame/line starts and ends, and buffers the kept pixels in a FIFO.
module gauss_result_rx
    import gauss_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int DEPTH = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] in_sum,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_sof,
    output logic             out_eol,
    output logic             frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    // The 3x3 window is complete from the third column / third line onwards
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(2);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_rdy_en;
    logic             r_frame_done;

    logic             w_accept;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_keep;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    fifo_word_t       w_wr_word;
    fifo_word_t       w_head;

    // in_ready depends only on registered state, so a pop in the same cycle
    // never opens the input; r_rdy_en holds it low until the first edge
    // after reset is released.
    assign in_ready   = r_rdy_en && !w_fifo_full;
    assign w_accept   = in_valid && in_ready;

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_keep     = w_accept && (r_col >= COL_FIRST) && (r_row >= ROW_FIRST);

    // Input enable: low in reset, high from the first clock edge after it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    // Raster position of the next sample; every accepted sample advances it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // One-cycle pulse after the last sample of a frame has been accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_col_last && w_row_last;
        end
    end

    assign frame_done = r_frame_done;

    // Build the FIFO word for the current sample: pixel plus position tags
    // NOTE: the default assignment at the top guarantees every bit is driven
    // on every path, so no latch can be inferred from this block.
    always_comb begin
        w_wr_word     = '0;
        w_wr_word.pix = normalize(in_sum);
        w_wr_word.sof = (r_col == COL_FIRST) && (r_row == ROW_FIRST);
        w_wr_word.eol = w_col_last;
    end

    gauss_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_keep),
        .i_wdata (w_wr_word),
        .i_pop   (out_ready),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // The head is only shown while valid, so outputs read as zero when empty
    assign out_valid = !w_fifo_empty;
    assign out_pix   = out_valid ? w_head.pix : '0;
    assign out_sof   = out_valid && w_head.sof;
    assign out_eol   = out_valid && w_head.eol;

endmodule
